// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, state encoding and constants for the iterative MDU
package mdu_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic a_signed(funct3_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(funct3_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  // Multiplies are funct3[2]==0, divides/remainders are funct3[2]==1.
  function automatic logic is_mul_op(funct3_e op);
    return ~op[2];
  endfunction

  function automatic logic [XLEN-1:0] abs_if(logic [XLEN-1:0] v, logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/adder32.sv
// rtl/adder32.sv - 32-bit ripple adder with carry in/out
// Ports: a, b (addends), cin (carry in); sum, cout (carry out).
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative RV32M multiply/divide unit, fixed 34-cycle latency
// Ports: clk; reset (sync, active-high); start, kill (abort in-flight op);
//        funct3 (RV32M op), a, b (rs1, rs2) in; busy, done (1-cycle pulse), result out.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import mdu_pkg::*;

  state_e            state_q, state_d;
  logic [4:0]        cnt;
  funct3_e           op_q;
  logic [XLEN-1:0]   a_q, mag_a, mag_b;
  logic              sign_a, sign_b;
  logic [2*XLEN-1:0] prod;

  funct3_e           op_in;
  logic              in_sa, in_sb, accept;
  logic [XLEN-1:0]   mag_a_in, mag_b_in;

  logic [XLEN-1:0]   add_x, add_y, add_sum;
  logic              add_cin, add_cout, is_mul, div_ge;
  logic [2*XLEN-1:0] step_next;

  logic              b_zero, ovf, neg_res;
  logic [XLEN-1:0]   q_neg, r_neg, h_neg, fix_result;
  logic [2*XLEN-1:0] prod_neg;

  // Operand capture: signed operands are stored as magnitudes, signs kept aside.
  assign op_in    = funct3_e'(funct3);
  assign in_sa    = a_signed(op_in) & a[XLEN-1];
  assign in_sb    = b_signed(op_in) & b[XLEN-1];
  assign mag_a_in = abs_if(a, in_sa);
  assign mag_b_in = abs_if(b, in_sb);
  assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);

  // One step per CALC cycle through the single shared adder.
  // Multiply: add multiplicand into the high half when the multiplier lsb is set, shift right.
  // Divide: shift remainder:quotient left, try remainder - divisor (a + ~b + 1).
  assign is_mul  = is_mul_op(op_q);
  assign add_x   = is_mul ? prod[2*XLEN-1:XLEN] : prod[2*XLEN-2:XLEN-1];
  assign add_y   = is_mul ? (mag_a & {XLEN{prod[0]}}) : ~mag_b;
  assign add_cin = ~is_mul;

  adder32 u_add (
    .a    (add_x),
    .b    (add_y),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The bit shifted out of the remainder makes the trial subtract succeed regardless of carry.
  assign div_ge = prod[2*XLEN-1] | add_cout;

  always_comb begin
    step_next = prod;
    if (is_mul) begin
      step_next = {add_cout, add_sum, prod[XLEN-1:1]};
    end else if (div_ge) begin
      step_next = {add_sum, prod[XLEN-2:0], 1'b1};
    end else begin
      step_next = {prod[2*XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and special cases; the low half holds quotient, high half remainder.
  assign b_zero   = (mag_b == '0);
  assign ovf      = (op_q == OP_DIV || op_q == OP_REM) && sign_a && sign_b &&
                    (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (mag_b == XLEN'(1));
  assign neg_res  = sign_a ^ sign_b;
  assign prod_neg = -prod;
  assign h_neg    = prod_neg[2*XLEN-1:XLEN];
  assign q_neg    = -prod[XLEN-1:0];
  assign r_neg    = -prod[2*XLEN-1:XLEN];

  always_comb begin
    fix_result = '0;
    case (op_q)
      OP_MUL:             fix_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU: fix_result = neg_res ? h_neg : prod[2*XLEN-1:XLEN];
      OP_MULHU:           fix_result = prod[2*XLEN-1:XLEN];
      OP_DIV:             fix_result = b_zero ? '1 : ovf ? a_q :
                                       (neg_res ? q_neg : prod[XLEN-1:0]);
      OP_DIVU:            fix_result = b_zero ? '1 : prod[XLEN-1:0];
      OP_REM:             fix_result = b_zero ? a_q : ovf ? '0 :
                                       (sign_a ? r_neg : prod[2*XLEN-1:XLEN]);
      OP_REMU:            fix_result = b_zero ? a_q : prod[2*XLEN-1:XLEN];
      default:            fix_result = '0;
    endcase
  end

  // Next state and outputs. kill only acts in CALC/FIX; in IDLE/DONE a start is taken.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (kill) state_d = S_IDLE;
        else if (cnt == 5'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        busy    = 1'b1;
        state_d = kill ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = start ? S_CALC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt     <= '0;
      op_q    <= OP_MUL;
      a_q     <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      prod    <= '0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op_in;
        a_q    <= a;
        mag_a  <= mag_a_in;
        mag_b  <= mag_b_in;
        sign_a <= in_sa;
        sign_b <= in_sb;
        cnt    <= '0;
        // Multiply seeds the multiplier in the low half; divide seeds the dividend.
        prod   <= is_mul_op(op_in) ? {{XLEN{1'b0}}, mag_b_in} : {{XLEN{1'b0}}, mag_a_in};
      end else if (state_q == S_CALC && !kill) begin
        prod <= step_next;
        cnt  <= cnt + 5'd1;
      end else if (state_q == S_FIX && !kill) begin
        result <= fix_result;
      end
    end
  end

endmodule
